// File: rtl/onn_phase_readout.sv
// Phase readout for the 3x5 ONN: per-neuron mismatch counting against the
// reference oscillator, change flags for control_fsm, final binary pattern.
module onn_phase_readout #(
  parameter int N       = 15,
  parameter int CW      = 8,
  parameter int MIN_PER = 4
) (
  input  logic         sclk,
  input  logic         re,
  input  logic [N-1:0] osc,
  input  logic         ref_osc,
  input  logic         state_cheak,
  input  logic         drop,
  input  logic         phi_to_no,
  output logic [N-1:0] state_changed,
  output logic [N-1:0] pattern,
  output logic         pattern_valid,
  output logic         meas_valid,
  output logic         stall
);

  typedef enum logic {
    WAIT_EDGE,
    MEAS
  } state_t;

  localparam logic [CW-1:0] PMAX = '1;
  localparam logic [CW-1:0] PMIN = CW'(MIN_PER);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t                state;
  logic [CW-1:0]         per;
  logic [N-1:0][CW-1:0]  mis;
  logic [N-1:0]          cur_pat;
  logic [N-1:0]          snap_pat;
  logic [N-1:0]          next_pat;
  logic [N-1:0]          smp;
  logic                  ref_d;
  logic                  chk_d;
  logic                  p2n_d;
  logic                  snap_ok;
  logic                  pend;
  logic                  rise;
  logic                  chk_rise;
  logic                  p2n_rise;
  logic                  close_ok;

  assign rise     = ref_osc & ~ref_d;
  assign chk_rise = state_cheak & ~chk_d;
  assign p2n_rise = phi_to_no & ~p2n_d;
  assign smp      = osc ^ {N{ref_osc}};
  assign close_ok = (state == MEAS) && rise && (per >= PMIN);

  // anti-phase when mismatch covers more than half the period; a tie is 0
  always_comb begin
    next_pat = '0;
    for (int i = 0; i < N; i++) begin
      next_pat[i] = {mis[i], 1'b0} > {1'b0, per};
    end
  end

  // period / mismatch counters and the edge-wait FSM
  always_ff @(posedge sclk or posedge re) begin
    if (re) begin
      state <= WAIT_EDGE;
      per   <= '0;
      mis   <= '0;
      stall <= 1'b0;
    end else begin
      stall <= 1'b0;
      if (drop) begin
        state <= WAIT_EDGE;
        per   <= '0;
        mis   <= '0;
      end else begin
        unique case (state)
          WAIT_EDGE: begin
            if (rise) begin
              state <= MEAS;
              per   <= ONE;
              for (int i = 0; i < N; i++) begin
                mis[i] <= {{(CW-1){1'b0}}, smp[i]};
              end
            end
          end
          MEAS: begin
            if (rise) begin
              per <= ONE;
              for (int i = 0; i < N; i++) begin
                mis[i] <= {{(CW-1){1'b0}}, smp[i]};
              end
            end else if (per == PMAX) begin
              stall <= 1'b1;
              state <= WAIT_EDGE;
              per   <= '0;
              mis   <= '0;
            end else begin
              per <= per + ONE;
              for (int i = 0; i < N; i++) begin
                mis[i] <= mis[i] + {{(CW-1){1'b0}}, smp[i]};
              end
            end
          end
          default: state <= WAIT_EDGE;
        endcase
      end
    end
  end

  // edge history, current pattern, snapshot and final pattern handoff
  always_ff @(posedge sclk or posedge re) begin
    if (re) begin
      ref_d         <= 1'b0;
      chk_d         <= 1'b0;
      p2n_d         <= 1'b0;
      cur_pat       <= '0;
      snap_pat      <= '0;
      snap_ok       <= 1'b0;
      meas_valid    <= 1'b0;
      pend          <= 1'b0;
      pattern       <= '0;
      pattern_valid <= 1'b0;
    end else begin
      ref_d         <= ref_osc;
      chk_d         <= state_cheak;
      p2n_d         <= phi_to_no;
      pattern_valid <= 1'b0;
      if (drop) begin
        meas_valid <= 1'b0;
        snap_ok    <= 1'b0;
      end else begin
        if (close_ok) begin
          cur_pat    <= next_pat;
          meas_valid <= 1'b1;
        end
        if (chk_rise && meas_valid) begin
          snap_pat <= cur_pat;
          snap_ok  <= 1'b1;
        end
        if (p2n_rise && meas_valid) begin
          pattern       <= cur_pat;
          pattern_valid <= 1'b1;
        end else if (pend && close_ok) begin
          pattern       <= next_pat;
          pattern_valid <= 1'b1;
          pend          <= 1'b0;
        end else if (p2n_rise) begin
          pend <= 1'b1;
        end
      end
    end
  end

  // change flags; all ones until a real snapshot exists
  always_ff @(posedge sclk or posedge re) begin
    if (re) begin
      state_changed <= '1;
    end else if (drop || !(meas_valid && snap_ok)) begin
      state_changed <= '1;
    end else begin
      state_changed <= cur_pat ^ snap_pat;
    end
  end

endmodule

// File: tb/tb_onn_phase_readout.sv
// Directed bench for onn_phase_readout: square-wave ref/osc stimulus with
// per-neuron phase shifts, hand-computed patterns and change flags.
module tb_onn_phase_readout;

  localparam int N = 15;

  logic         sclk = 1'b0;
  logic         re;
  logic [N-1:0] osc;
  logic         ref_osc;
  logic         state_cheak;
  logic         drop;
  logic         phi_to_no;
  logic [N-1:0] state_changed;
  logic [N-1:0] pattern;
  logic         pattern_valid;
  logic         meas_valid;
  logic         stall;

  int checks = 0;
  int errors = 0;
  int pv_cnt = 0;
  int sh [N];

  always #5 sclk = ~sclk;

  onn_phase_readout #(.N(N), .CW(8), .MIN_PER(4)) dut (
    .sclk          (sclk),
    .re            (re),
    .osc           (osc),
    .ref_osc       (ref_osc),
    .state_cheak   (state_cheak),
    .drop          (drop),
    .phi_to_no     (phi_to_no),
    .state_changed (state_changed),
    .pattern       (pattern),
    .pattern_valid (pattern_valid),
    .meas_valid    (meas_valid),
    .stall         (stall)
  );

  // pulse counter for pattern_valid
  always @(negedge sclk) if (pattern_valid === 1'b1) pv_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_per(input int len, input int hi, input int n);
    for (int p = 0; p < n; p++) begin
      for (int k = 0; k < len; k++) begin
        ref_osc = (k < hi);
        for (int i = 0; i < N; i++) begin
          osc[i] = (((k - sh[i] + 4 * len) % len) < hi);
        end
        @(negedge sclk);
      end
    end
  endtask

  task automatic strobe(input logic [N-1:0] e_in, input logic [N-1:0] e_out,
                        input string tag);
    state_cheak = 1'b1;
    @(negedge sclk);
    chk({tag, "_in"}, 32'(state_changed), 32'(e_in));
    state_cheak = 1'b0;
    @(negedge sclk);
    chk({tag, "_out"}, 32'(state_changed), 32'(e_out));
  endtask

  task automatic phi(input logic [N-1:0] e, input string tag);
    phi_to_no = 1'b1;
    @(negedge sclk);
    chk({tag, "_pv"}, 32'(pattern_valid), 32'd1);
    chk({tag, "_pat"}, 32'(pattern), 32'(e));
    @(negedge sclk);
    chk({tag, "_pv_once"}, 32'(pattern_valid), 32'd0);
    phi_to_no = 1'b0;
    @(negedge sclk);
  endtask

  task automatic clr_sh();
    for (int i = 0; i < N; i++) sh[i] = 0;
  endtask

  int nst;
  int at;
  int base;

  initial begin
    re          = 1'b1;
    osc         = '0;
    ref_osc     = 1'b0;
    state_cheak = 1'b0;
    drop        = 1'b0;
    phi_to_no   = 1'b0;
    clr_sh();
    repeat (2) @(negedge sclk);
    chk("rst_sc", 32'(state_changed), 32'h7fff);
    chk("rst_pat", 32'(pattern), 32'h0);
    chk("rst_pv", 32'(pattern_valid), 32'h0);
    chk("rst_mv", 32'(meas_valid), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    re = 1'b0;

    // in-phase array, period 10
    run_per(10, 5, 1);
    chk("p1_mv", 32'(meas_valid), 32'h0);
    run_per(10, 5, 2);
    chk("p2_mv", 32'(meas_valid), 32'h1);
    chk("p2_sc", 32'(state_changed), 32'h7fff);
    strobe(15'h7fff, 15'h0000, "chk1");
    strobe(15'h0000, 15'h0000, "chk2");

    // neurons 0 and 14 anti-phase
    sh[0]  = 5;
    sh[14] = 5;
    run_per(10, 5, 3);
    chk("inv_sc", 32'(state_changed), 32'h4001);
    phi(15'h4001, "inv");

    // async reset while measuring
    re = 1'b1;
    #1;
    chk("re_sc", 32'(state_changed), 32'h7fff);
    chk("re_pat", 32'(pattern), 32'h0);
    chk("re_pv", 32'(pattern_valid), 32'h0);
    chk("re_mv", 32'(meas_valid), 32'h0);
    chk("re_stall", 32'(stall), 32'h0);
    @(negedge sclk);
    re = 1'b0;

    // partial shifts: mis 4/6/10 of 10
    sh[3] = 2;
    sh[4] = 3;
    sh[5] = 5;
    run_per(10, 5, 3);
    phi(15'h4031, "shift");
    // period 8, neuron 6 mis 4 -> tie
    sh[6] = 2;
    run_per(8, 4, 3);
    phi(15'h4031, "tie");

    // change detection between checks
    clr_sh();
    run_per(10, 5, 3);
    strobe(15'h7fff, 15'h0000, "t5a");
    sh[7] = 5;
    run_per(10, 5, 3);
    chk("t5_pre", 32'(state_changed), 32'h0080);
    strobe(15'h0080, 15'h0000, "t5b");
    strobe(15'h0000, 15'h0000, "t5c");

    // ref stuck low -> one stall pulse
    run_per(10, 5, 3);
    nst = 0;
    at  = 0;
    for (int h = 1; h <= 300; h++) begin
      @(negedge sclk);
      if (stall === 1'b1) begin
        nst++;
        at = h;
      end
    end
    chk("stall_cnt", 32'(nst), 32'd1);
    chk("stall_at", 32'(at), 32'd246);
    chk("stall_keep", 32'(state_changed), 32'h0);

    // short periods are discarded
    clr_sh();
    run_per(3, 1, 4);
    chk("short_sc", 32'(state_changed), 32'h0);
    chk("short_mv", 32'(meas_valid), 32'h1);
    phi(15'h0080, "keep");

    // drop invalidates everything but the patterns
    drop = 1'b1;
    @(negedge sclk);
    drop = 1'b0;
    chk("drop_sc", 32'(state_changed), 32'h7fff);
    chk("drop_mv", 32'(meas_valid), 32'h0);
    chk("drop_pat", 32'(pattern), 32'h0080);

    // request while invalid is served at first close
    phi_to_no = 1'b1;
    @(negedge sclk);
    chk("pend_pv", 32'(pattern_valid), 32'h0);
    phi_to_no = 1'b0;
    @(negedge sclk);
    base  = pv_cnt;
    sh[1] = 5;
    run_per(10, 5, 2);
    @(negedge sclk);
    chk("pend_cnt", 32'(pv_cnt - base), 32'd1);
    chk("pend_pat", 32'(pattern), 32'h0002);
    chk("pend_mv", 32'(meas_valid), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
